updown_count_monitor: RTL and testbench

//  Checker stage that sits directly downstream of the 4-bit up/down counter.

---
 rtl/updown_count_monitor.sv | 125 ++++++++++++
 tb/tb_updown_count_monitor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/updown_count_monitor.sv
// rtl/updown_count_monitor.sv - sequence checker for an up/down counter: wrap detection, wrap statistics, first-error capture
module updown_count_monitor #(
  parameter int WIDTH   = 4,
  parameter int WRAP_CW = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               up_down,
  input  logic               ctr_reset,
  input  logic [WIDTH-1:0]   counter,
  input  logic               clear,
  output logic               wrap_up,
  output logic               wrap_down,
  output logic [WRAP_CW-1:0] wrap_count,
  output logic               err,
  output logic               err_pulse,
  output logic [WIDTH-1:0]   err_exp,
  output logic [WIDTH-1:0]   err_act
);

  localparam logic [WIDTH-1:0]   CNT_ZERO = '0;
  localparam logic [WIDTH-1:0]   CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0]   CNT_MAX  = '1;
  localparam logic [WRAP_CW-1:0] WC_ONE   = WRAP_CW'(1);
  localparam logic [WRAP_CW-1:0] WC_MAX   = '1;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] prev_cnt;
  logic             prev_ud;
  logic             prev_rst;

  logic [WIDTH-1:0] expected;
  logic             match;
  logic             wrap_up_det;
  logic             wrap_dn_det;

  // Expected value of this sample derived from last cycle's counter and controls
  always_comb begin
    expected = CNT_ZERO;
    if (prev_rst)
      expected = CNT_ZERO;
    else if (!prev_ud)
      expected = prev_cnt + CNT_ONE;
    else
      expected = prev_cnt - CNT_ONE;
    match = (counter == expected);
    // A zero produced by ctr_reset is never a wrap, hence the prev_rst gate
    wrap_up_det = match && !prev_rst && !prev_ud && (prev_cnt == CNT_MAX)  && (counter == CNT_ZERO);
    wrap_dn_det = match && !prev_rst &&  prev_ud && (prev_cnt == CNT_ZERO) && (counter == CNT_MAX);
  end

  // History registers track the counter every cycle, whatever the FSM state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_cnt <= CNT_ZERO;
      prev_ud  <= 1'b0;
      prev_rst <= 1'b0;
    end else begin
      prev_cnt <= counter;
      prev_ud  <= up_down;
      prev_rst <= ctr_reset;
    end
  end

  // Checker FSM with registered pulses, saturating wrap count and first-error capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_INIT;
      wrap_up    <= 1'b0;
      wrap_down  <= 1'b0;
      wrap_count <= '0;
      err        <= 1'b0;
      err_pulse  <= 1'b0;
      err_exp    <= CNT_ZERO;
      err_act    <= CNT_ZERO;
    end else begin
      wrap_up   <= 1'b0;
      wrap_down <= 1'b0;
      err_pulse <= 1'b0;
      if (clear) begin
        // clear wins over anything detected on the same sample
        state      <= ST_INIT;
        wrap_count <= '0;
        err        <= 1'b0;
        err_exp    <= CNT_ZERO;
        err_act    <= CNT_ZERO;
      end else begin
        case (state)
          ST_INIT: begin
            // history is not yet trustworthy; skip this sample
            state <= ST_TRACK;
          end
          ST_TRACK: begin
            if (!match) begin
              state     <= ST_ERROR;
              err       <= 1'b1;
              err_pulse <= 1'b1;
              err_exp   <= expected;
              err_act   <= counter;
            end else if (wrap_up_det || wrap_dn_det) begin
              wrap_up   <= wrap_up_det;
              wrap_down <= wrap_dn_det;
              if (wrap_count != WC_MAX)
                wrap_count <= wrap_count + WC_ONE;
            end
          end
          ST_ERROR: begin
            // frozen until clear or reset
            state <= ST_ERROR;
          end
          default: begin
            state <= ST_INIT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_updown_count_monitor.sv
// tb/tb_updown_count_monitor.sv - directed table-driven bench for updown_count_monitor
module tb_updown_count_monitor;

  logic       clk;
  logic       reset;
  logic       up_down;
  logic       ctr_reset;
  logic [3:0] counter;
  logic       clear;

  logic       wrap_up, wrap_down, err, err_pulse;
  logic [7:0] wrap_count;
  logic [3:0] err_exp, err_act;

  logic       wu2, wd2, er2, ep2;
  logic [1:0] wc2;
  logic [3:0] ex2, ac2;

  int n_checks;
  int n_fail;

  updown_count_monitor #(.WIDTH(4), .WRAP_CW(8)) dut (
    .clk(clk), .reset(reset), .up_down(up_down), .ctr_reset(ctr_reset),
    .counter(counter), .clear(clear),
    .wrap_up(wrap_up), .wrap_down(wrap_down), .wrap_count(wrap_count),
    .err(err), .err_pulse(err_pulse), .err_exp(err_exp), .err_act(err_act)
  );

  updown_count_monitor #(.WIDTH(4), .WRAP_CW(2)) dut_sat (
    .clk(clk), .reset(reset), .up_down(up_down), .ctr_reset(ctr_reset),
    .counter(counter), .clear(clear),
    .wrap_up(wu2), .wrap_down(wd2), .wrap_count(wc2),
    .err(er2), .err_pulse(ep2), .err_exp(ex2), .err_act(ac2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       cr;
    logic       ud;
    logic [3:0] cnt;
    logic       clr;
    logic       wu;
    logic       wd;
    logic [7:0] wc;
    logic       er;
    logic       ep;
    logic [3:0] ex;
    logic [3:0] ac;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic cr, input logic ud, input logic [3:0] cnt, input logic clr,
                     input logic wu, input logic wd, input logic [7:0] wc,
                     input logic er, input logic ep, input logic [3:0] ex, input logic [3:0] ac);
    vec_t v;
    v.cr = cr; v.ud = ud; v.cnt = cnt; v.clr = clr;
    v.wu = wu; v.wd = wd; v.wc = wc; v.er = er; v.ep = ep; v.ex = ex; v.ac = ac;
    tbl.push_back(v);
  endtask

  task automatic step(input logic cr, input logic ud, input logic [3:0] cnt, input logic clr);
    ctr_reset = cr;
    up_down   = ud;
    counter   = cnt;
    clear     = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b0;
    up_down   = 1'b0;
    ctr_reset = 1'b0;
    counter   = 4'd0;
    clear     = 1'b0;

    // Down-count wrap through 0, reach 5 via ctr_reset, toggle, then error, freeze and clear
    add(0,1,4'd4,0,  0,0,8'd1,0,0,4'd0,4'd0);
    add(0,1,4'd3,0,  0,0,8'd1,0,0,4'd0,4'd0);
    add(0,1,4'd2,0,  0,0,8'd1,0,0,4'd0,4'd0);
    add(0,1,4'd1,0,  0,0,8'd1,0,0,4'd0,4'd0);
    add(0,1,4'd0,0,  0,0,8'd1,0,0,4'd0,4'd0);
    add(0,1,4'd15,0, 0,1,8'd2,0,0,4'd0,4'd0);
    add(1,0,4'd14,0, 0,0,8'd2,0,0,4'd0,4'd0);
    for (int k = 0; k <= 4; k++)
      add(0,0,4'(k),0, 0,0,8'd2,0,0,4'd0,4'd0);
    add(0,0,4'd5,0,  0,0,8'd2,0,0,4'd0,4'd0);
    add(0,1,4'd6,0,  0,0,8'd2,0,0,4'd0,4'd0);
    add(0,0,4'd5,0,  0,0,8'd2,0,0,4'd0,4'd0);
    add(0,1,4'd6,0,  0,0,8'd2,0,0,4'd0,4'd0);
    add(0,0,4'd5,0,  0,0,8'd2,0,0,4'd0,4'd0);
    add(0,0,4'd6,0,  0,0,8'd2,0,0,4'd0,4'd0);
    add(0,0,4'd7,0,  0,0,8'd2,0,0,4'd0,4'd0);
    add(0,0,4'd9,0,  0,0,8'd2,1,1,4'd8,4'd9);
    for (int k = 10; k <= 15; k++)
      add(0,0,4'(k),0, 0,0,8'd2,1,0,4'd8,4'd9);
    add(0,0,4'd0,0,  0,0,8'd2,1,0,4'd8,4'd9);
    add(0,0,4'd1,1,  0,0,8'd0,0,0,4'd0,4'd0);
    add(0,0,4'd5,0,  0,0,8'd0,0,0,4'd0,4'd0);
    add(0,0,4'd6,0,  0,0,8'd0,0,0,4'd0,4'd0);
    add(0,0,4'd7,0,  0,0,8'd0,0,0,4'd0,4'd0);
    add(0,0,4'd9,1,  0,0,8'd0,0,0,4'd0,4'd0);
    add(0,0,4'd10,0, 0,0,8'd0,0,0,4'd0,4'd0);
    add(0,0,4'd11,0, 0,0,8'd0,0,0,4'd0,4'd0);

    // Reset state
    #12;
    check("rst_wrap_up",    32'(wrap_up),    32'd0);
    check("rst_wrap_down",  32'(wrap_down),  32'd0);
    check("rst_wrap_count", 32'(wrap_count), 32'd0);
    check("rst_err",        32'(err),        32'd0);
    check("rst_err_pulse",  32'(err_pulse),  32'd0);
    check("rst_err_exp",    32'(err_exp),    32'd0);
    check("rst_err_act",    32'(err_act),    32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Up-count 0..15,0..3 after a ctr_reset; one wrap_up on the post-15 zero
    step(1, 0, 4'd5, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 4'(i % 16), 0);
      check($sformatf("up_wrap_up[%0d]", i), 32'(wrap_up), (i == 16) ? 32'd1 : 32'd0);
      check($sformatf("up_err[%0d]", i),     32'(err),     32'd0);
    end
    check("up_wrap_count", 32'(wrap_count), 32'd1);

    foreach (tbl[i]) begin
      step(tbl[i].cr, tbl[i].ud, tbl[i].cnt, tbl[i].clr);
      check($sformatf("tbl[%0d].wrap_up", i),    32'(wrap_up),    32'(tbl[i].wu));
      check($sformatf("tbl[%0d].wrap_down", i),  32'(wrap_down),  32'(tbl[i].wd));
      check($sformatf("tbl[%0d].wrap_count", i), 32'(wrap_count), 32'(tbl[i].wc));
      check($sformatf("tbl[%0d].err", i),        32'(err),        32'(tbl[i].er));
      check($sformatf("tbl[%0d].err_pulse", i),  32'(err_pulse),  32'(tbl[i].ep));
      check($sformatf("tbl[%0d].err_exp", i),    32'(err_exp),    32'(tbl[i].ex));
      check($sformatf("tbl[%0d].err_act", i),    32'(err_act),    32'(tbl[i].ac));
    end

    // ctr_reset at 15 while counting up: zero is not a wrap
    step(0, 0, 4'd12, 0);
    step(0, 0, 4'd13, 0);
    step(0, 0, 4'd14, 0);
    step(1, 0, 4'd15, 0);
    step(0, 0, 4'd0, 0);
    check("crst_wrap_up",    32'(wrap_up),    32'd0);
    check("crst_err",        32'(err),        32'd0);
    check("crst_wrap_count", 32'(wrap_count), 32'd0);

    // A real wrap, then async reset between edges
    for (int k = 1; k <= 15; k++)
      step(0, 0, 4'(k), 0);
    step(0, 0, 4'd0, 0);
    check("pre_arst_wrap_up",    32'(wrap_up),    32'd1);
    check("pre_arst_wrap_count", 32'(wrap_count), 32'd1);
    #3;
    reset = 1'b0;
    #1;
    check("arst_wrap_up",    32'(wrap_up),    32'd0);
    check("arst_wrap_count", 32'(wrap_count), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(0, 0, 4'd9, 0);
    check("arst_first_unchecked_err", 32'(err),       32'd0);
    check("arst_first_unchecked_ep",  32'(err_pulse), 32'd0);
    step(0, 0, 4'd10, 0);
    check("arst_second_err", 32'(err), 32'd0);

    // Saturation: five wraps into 8-bit and 2-bit wrap counters
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1, 0, 4'd7, 0);
    step(0, 0, 4'd0, 0);
    for (int w = 1; w <= 5; w++) begin
      for (int k = 1; k <= 15; k++)
        step(0, 0, 4'(k), 0);
      step(0, 0, 4'd0, 0);
      check($sformatf("sat_wu2[%0d]", w),       32'(wu2),        32'd1);
      check($sformatf("sat_wc2[%0d]", w),       32'(wc2),        (w > 3) ? 32'd3 : 32'(w));
      check($sformatf("sat_wrap_count[%0d]", w), 32'(wrap_count), 32'(w));
    end
    check("sat_err2", 32'(er2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
